// File: rtl/glitch_sched_if.sv
// glitch_sched_if: configuration, control and status bundle for glitch_sched.
//   master : software/host side (drives cfg_*, arm, trigger, abort)
//   slave  : scheduler side (drives glitch_sel, armed, busy, done, glitch_count)
//   cfg_we/cfg_delay/cfg_width/cfg_gap/cfg_reps : config write port
//   arm, trigger (DV_1), abort                  : run control
//   glitch_sel, armed, busy, done, glitch_count : registered status
interface glitch_sched_if #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
);
  logic             cfg_we;
  logic [CNT_W-1:0] cfg_delay;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [REP_W-1:0] cfg_reps;
  logic             arm;
  logic             trigger;
  logic             abort;
  logic             glitch_sel;
  logic             armed;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] glitch_count;

  modport master (
    output cfg_we, cfg_delay, cfg_width, cfg_gap, cfg_reps, arm, trigger, abort,
    input  glitch_sel, armed, busy, done, glitch_count
  );

  modport slave (
    input  cfg_we, cfg_delay, cfg_width, cfg_gap, cfg_reps, arm, trigger, abort,
    output glitch_sel, armed, busy, done, glitch_count
  );
endinterface

// File: rtl/glitch_sched.sv
// glitch_sched: trigger-aligned clock-glitch sequencer. Once armed, a rising
// edge on trigger starts a delay, then glitch_sel pulses max(width,1) cycles,
// repeated max(reps,1) times with gap cycles between, then done pulses.
// Ports:
//   clk_in1 : system clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : glitch_sched_if.slave (config, arm/trigger/abort, status)
// Build option: define GLITCH_SCHED_REARM_EN to return to ARMED after each
// burst (glitch_count cleared) instead of IDLE; abort leaves that mode.
module glitch_sched #(
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic           clk_in1,
  input  logic           rst,
  glitch_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_DELAY, S_GLITCH, S_GAP, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dly_q, dly_d, wid_q, wid_d, gap_q, gap_d;
  logic [REP_W-1:0] reps_q, reps_d, gcnt_q, gcnt_d;
  logic             trig_prev_q;
  logic             glitch_sel_q, glitch_sel_d;
  logic             armed_q, armed_d, busy_q, busy_d, done_q, done_d;

  logic             rise;
  logic [CNT_W-1:0] wid_m1;
  logic [REP_W-1:0] reps_eff;
  logic [REP_W:0]   gcnt_inc;
  logic             last_pulse;

  assign rise     = bus.trigger & ~trig_prev_q;
  // Phase counters load length-1 and end at 0; width 0 behaves like 1.
  assign wid_m1   = (wid_q == '0) ? '0 : wid_q - CNT_ONE;
  assign reps_eff = (reps_q == '0) ? REP_ONE : reps_q;
  // Compared one bit wider so a saturated count still terminates the burst.
  assign gcnt_inc   = {1'b0, gcnt_q} + {{REP_W{1'b0}}, 1'b1};
  assign last_pulse = gcnt_inc >= {1'b0, reps_eff};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    gap_d   = gap_q;
    reps_d  = reps_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cfg_we) begin
          dly_d  = bus.cfg_delay;
          wid_d  = bus.cfg_width;
          gap_d  = bus.cfg_gap;
          reps_d = bus.cfg_reps;
        end
        if (bus.arm) begin
          state_d = S_ARMED;
          gcnt_d  = '0;
        end
      end
      S_ARMED: begin
        if (rise) begin
          if (dly_q == '0) begin
            state_d = S_GLITCH;
            cnt_d   = wid_m1;
          end else begin
            state_d = S_DELAY;
            cnt_d   = dly_q - CNT_ONE;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_GLITCH;
          cnt_d   = wid_m1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GLITCH: begin
        if (cnt_q == '0) begin
          if (gcnt_q != '1) gcnt_d = gcnt_q + REP_ONE;
          if (last_pulse) begin
            state_d = S_DONE;
          end else if (gap_q == '0) begin
            // Zero gap: stay in GLITCH so pulses merge into one high period.
            cnt_d = wid_m1;
          end else begin
            state_d = S_GAP;
            cnt_d   = gap_q - CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_GLITCH;
          cnt_d   = wid_m1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
`ifdef GLITCH_SCHED_REARM_EN
        state_d = S_ARMED;
        gcnt_d  = '0;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything: no config write, no arm, count held.
    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      wid_d   = wid_q;
      gap_d   = gap_q;
      reps_d  = reps_q;
      gcnt_d  = gcnt_q;
    end
  end

  // Status outputs are registered copies of the current state, which puts
  // the first glitch cycle at trigger edge + delay + 1.
  always_comb begin
    glitch_sel_d = (state_q == S_GLITCH) && !bus.abort;
    armed_d      = (state_q == S_ARMED) && !bus.abort;
    busy_d       = (state_q == S_DELAY || state_q == S_GLITCH || state_q == S_GAP) && !bus.abort;
    done_d       = (state_q == S_DONE) && !bus.abort;
  end

  always_ff @(posedge clk_in1 or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dly_q        <= '0;
      wid_q        <= CNT_ONE;
      gap_q        <= '0;
      reps_q       <= REP_ONE;
      gcnt_q       <= '0;
      trig_prev_q  <= 1'b0;
      glitch_sel_q <= 1'b0;
      armed_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dly_q        <= dly_d;
      wid_q        <= wid_d;
      gap_q        <= gap_d;
      reps_q       <= reps_d;
      gcnt_q       <= gcnt_d;
      trig_prev_q  <= bus.trigger;
      glitch_sel_q <= glitch_sel_d;
      armed_q      <= armed_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.glitch_sel   = glitch_sel_q;
  assign bus.armed        = armed_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.glitch_count = gcnt_q;

endmodule

// File: doc/glitch_sched.md
Name: glitch_sched

Overview:
- Sequences clock-glitch injection for the glitcher datapath.
- After software arms it, the block waits for a trigger rising edge, usually the stage-1 data-valid DV_1.
- It then counts a programmable delay and asserts the glitch-mux select for a programmable width.
- It can repeat that pulse a programmable number of times, separated by a programmable gap, and then reports completion.
- It replaces the free-running counter as the source of the mux select, so glitches land at a deterministic offset from the data under test.

Parameters:
- CNT_W, 16: width of the delay, width and gap counters/config fields.
- REP_W, 8: width of the repetition config and glitch_count.

Ports:
- clk_in1  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  config write strobe; accepted only in IDLE.
- cfg_delay  in  CNT_W  cycles from trigger to first glitch.
- cfg_width  in  CNT_W  cycles glitch_sel stays high per pulse; 0 is treated as 1.
- cfg_gap  in  CNT_W  cycles low between pulses.
- cfg_reps  in  REP_W  number of pulses; 0 is treated as 1.
- arm  in  1  arm request; accepted only in IDLE.
- trigger  in  1  trigger source (DV_1); the rising edge is used.
- abort  in  1  synchronous abort, highest priority.
- glitch_sel  out  1  registered select to the glitch mux; 1 selects the glitch clock.
- armed  out  1  high in ARMED.
- busy  out  1  high in DELAY, GLITCH or GAP.
- done  out  1  one-cycle completion pulse.
- glitch_count  out  REP_W  pulses issued in the current or last run.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0.
  - Config registers: delay=0, width=1, gap=0, reps=1.
  - trigger history register cleared to 0.
- All outputs are registered.
- Trigger edge detection: trig_prev is registered every cycle. A rising edge is trigger=1 && trig_prev=0.
- IDLE:
  - cfg_we=1 latches all four config fields.
  - arm=1 moves to ARMED.
  - If cfg_we and arm are high in the same cycle, the new config is used.
  - glitch_count is cleared on arm.
- ARMED: a trigger rising edge loads the counter and enters DELAY. If delay=0, it enters GLITCH directly.
- DELAY: counts delay cycles, then enters GLITCH.
- Latency: with the trigger edge sampled at edge T, glitch_sel is high from edge T+delay+1 for exactly max(width,1) cycles.
- GLITCH:
  - glitch_sel=1.
  - On the last cycle, glitch_count increments (saturating at all-ones).
  - If glitch_count+1 ≥ max(reps,1), go to DONE; otherwise go to GAP.
  - If gap=0, go straight back to GLITCH, so consecutive pulses merge into one continuous high period.
- GAP: glitch_sel=0 for gap cycles, then GLITCH.
- DONE: done=1 for one cycle, then IDLE. glitch_count is held until the next arm.
- abort=1 in any state:
  - Next state is IDLE; glitch_sel=0 at the next edge.
  - done is not pulsed; glitch_count is held.
  - abort overrides a simultaneous trigger, arm or cfg_we.
- Trigger edges outside ARMED are ignored. A trigger still high when arming does not fire; a fresh rising edge is required.
- cfg_we outside IDLE is ignored; config is stable during a run.
- Counters never wrap: the delay, width and gap counters reload per phase. Maximum delay is 2^CNT_W−1 cycles.
- Reset asserted mid-run immediately forces glitch_sel=0 and IDLE.

Optional Feature:
- GLITCH_SCHED_REARM_EN defined:
  - DONE returns to ARMED instead of IDLE, with glitch_count cleared, so every trigger edge produces a burst.
  - Leave this mode with abort.
- GLITCH_SCHED_REARM_EN undefined: single-shot; DONE goes to IDLE and a new arm is required.

Test Plan:
- Reset then config delay=3, width=2, reps=1, arm; trigger rises at edge T → glitch_sel high at edges T+4 and T+5 only, done at T+6, glitch_count=1.
- Config delay=0, width=1, gap=2, reps=3 → glitch_sel pattern 1,0,0,1,0,0,1 starting at T+1; done pulses once; glitch_count=3.
- Config width=0, reps=0 → treated as 1: a single one-cycle pulse.
- Config gap=0, width=2, reps=2 → glitch_sel high for 4 consecutive cycles.
- Trigger held high across arm → no fire until trigger falls and rises again.
- cfg_we during DELAY → ignored.
- abort during GLITCH → glitch_sel 0 at the next edge, no done, state IDLE.
- rst low mid-GAP → all outputs 0 immediately.
- With GLITCH_SCHED_REARM_EN: two trigger edges → two bursts without re-arm, armed high between them.
